// File: rtl/fpu_pkg.sv
// Shared binary64 definitions for the FPU: field widths, constants,
// divider state encoding and small classification helpers.
package fpu_pkg;

    localparam int unsigned WORD_W   = 64;
    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 11;
    localparam int unsigned FRAC_W   = 52;
    localparam int unsigned MANT_W   = FRAC_W + 1;
    localparam int unsigned REM_W    = MANT_W + 1;
    localparam int unsigned QUOT_W   = MANT_W + 2;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned ECALC_W  = 13;
    localparam int unsigned EXP_BIAS = 1023;

    localparam logic [EXP_W-1:0]  EXP_MAX   = 11'h7FF;
    localparam logic [WORD_W-1:0] QNAN      = 64'h7FF8000000000000;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(QUOT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } div_state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic divzero;
        logic overflow;
        logic underflow;
    } div_flags_t;

    // Subnormals classify as zero (denormals-are-zero).
    function automatic fp_class_t classify(input logic [WORD_W-2:0] x);
        fp_class_t c;
        c.zero = (x[WORD_W-2:FRAC_W] == '0);
        c.inf  = (x[WORD_W-2:FRAC_W] == EXP_MAX) && (x[FRAC_W-1:0] == '0);
        c.nan  = (x[WORD_W-2:FRAC_W] == EXP_MAX) && (x[FRAC_W-1:0] != '0);
        return c;
    endfunction

    function automatic logic [WORD_W-1:0] inf_word(input logic s);
        return {s, EXP_MAX, FRAC_W'(0)};
    endfunction

    function automatic logic [WORD_W-1:0] zero_word(input logic s);
        return {s, (WORD_W-1)'(0)};
    endfunction

endpackage

// File: rtl/fpu_div_classify.sv
// Operand classification and special-case result/flag selection for the
// sequential divider; purely combinational.
module fpu_div_classify
    import fpu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              special_c,
    output logic [WORD_W-1:0] special_result_c,
    output div_flags_t        special_flags_c
);

    fp_class_t class_a;
    fp_class_t class_b;
    logic      sign;

    // Priority chain: NaN, invalid, divide-by-zero, then exact zero/Inf results.
    always_comb begin
        class_a          = classify(a[WORD_W-2:0]);
        class_b          = classify(b[WORD_W-2:0]);
        sign             = a[WORD_W-1] ^ b[WORD_W-1];
        special_c        = (|class_a) | (|class_b);
        special_result_c = '0;
        special_flags_c  = '0;

        if (class_a.nan || class_b.nan) begin
            special_result_c = QNAN;
        end else if ((class_a.zero && class_b.zero) || (class_a.inf && class_b.inf)) begin
            special_result_c        = QNAN;
            special_flags_c.invalid = 1'b1;
        end else if (class_b.zero) begin
            // Inf/0 is an exact infinity, so only a finite dividend raises divzero.
            special_result_c        = inf_word(sign);
            special_flags_c.divzero = !class_a.inf;
        end else if (class_a.zero) begin
            special_result_c = zero_word(sign);
        end else if (class_a.inf) begin
            special_result_c = inf_word(sign);
        end else if (class_b.inf) begin
            special_result_c = zero_word(sign);
        end
    end

endmodule

// File: rtl/fpu_div_seq.sv
// Iterative binary64 divider: one restoring quotient bit per clock, then a
// single round/pack cycle. One operation in flight, valid/ready on both sides.
module fpu_div_seq
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic              flag_invalid,
    output logic              flag_divzero,
    output logic              flag_overflow,
    output logic              flag_underflow
);

    div_state_t state;
    div_state_t state_next;

    logic [SIGN_W-1:0]         sign_q;
    logic signed [ECALC_W-1:0] exp_q;
    logic [REM_W-1:0]          rem_q;
    logic [MANT_W-1:0]         div_q;
    logic [QUOT_W-1:0]         quot_q;
    logic [CNT_W-1:0]          cnt_q;
    div_flags_t                flags_q;

    logic              accept_c;
    logic              special_c;
    logic [WORD_W-1:0] special_result_c;
    div_flags_t        special_flags_c;

    logic              step_ge_c;
    logic [REM_W-1:0]  rem_diff_c;
    logic [REM_W-1:0]  rem_next_c;

    logic                      q_top_c;
    logic [FRAC_W-1:0]         frac_pre_c;
    logic                      guard_c;
    logic                      sticky_c;
    logic                      round_up_c;
    logic [MANT_W-1:0]         frac_sum_c;
    logic signed [ECALC_W-1:0] exp_rnd_c;
    logic                      ovf_c;
    logic                      unf_c;
    logic [WORD_W-1:0]         rnd_word_c;

    assign accept_c = in_valid & in_ready;

    fpu_div_classify u_classify (
        .a                (a),
        .b                (b),
        .special_c        (special_c),
        .special_result_c (special_result_c),
        .special_flags_c  (special_flags_c)
    );

    // Restoring step; the remainder stays below 2*D so REM_W bits suffice.
    assign step_ge_c  = rem_q >= {1'b0, div_q};
    assign rem_diff_c = step_ge_c ? (rem_q - {1'b0, div_q}) : rem_q;
    assign rem_next_c = rem_diff_c << 1;

    // Normalise on the leading quotient bit, round to nearest even, then range-check.
    always_comb begin
        q_top_c    = quot_q[QUOT_W-1];
        frac_pre_c = q_top_c ? quot_q[QUOT_W-2:2] : quot_q[QUOT_W-3:1];
        guard_c    = q_top_c ? quot_q[1] : quot_q[0];
        sticky_c   = (q_top_c & quot_q[0]) | (|rem_q);
        round_up_c = guard_c & (sticky_c | frac_pre_c[0]);
        frac_sum_c = {1'b0, frac_pre_c} + MANT_W'(round_up_c);
        exp_rnd_c  = exp_q - (q_top_c ? 13'sd0 : 13'sd1)
                           + (frac_sum_c[FRAC_W] ? 13'sd1 : 13'sd0);
        ovf_c      = exp_rnd_c >= 13'sd2047;
        unf_c      = exp_rnd_c <= 13'sd0;
        rnd_word_c = {sign_q, exp_rnd_c[EXP_W-1:0], frac_sum_c[FRAC_W-1:0]};
        if (ovf_c) begin
            rnd_word_c = inf_word(sign_q);
        end else if (unf_c) begin
            rnd_word_c = zero_word(sign_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = special_c ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == LAST_STEP) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sign_q    <= '0;
            exp_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            result    <= '0;
            flags_q   <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        sign_q  <= a[WORD_W-1] ^ b[WORD_W-1];
                        exp_q   <= $signed({2'b00, a[WORD_W-2:FRAC_W]})
                                 - $signed({2'b00, b[WORD_W-2:FRAC_W]})
                                 + $signed(ECALC_W'(EXP_BIAS));
                        rem_q   <= {2'b01, a[FRAC_W-1:0]};
                        div_q   <= {1'b1, b[FRAC_W-1:0]};
                        quot_q  <= '0;
                        cnt_q   <= '0;
                        result  <= special_c ? special_result_c : '0;
                        flags_q <= special_c ? special_flags_c : '0;
                    end
                end
                DIVIDE: begin
                    rem_q  <= rem_next_c;
                    quot_q <= {quot_q[QUOT_W-2:0], step_ge_c};
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                ROUND: begin
                    result  <= rnd_word_c;
                    flags_q <= '{invalid: 1'b0, divzero: 1'b0,
                                 overflow: ovf_c, underflow: unf_c};
                end
                DONE: begin
                    if (out_ready) begin
                        result  <= '0;
                        flags_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flag_invalid   = flags_q.invalid;
    assign flag_divzero   = flags_q.divzero;
    assign flag_overflow  = flags_q.overflow;
    assign flag_underflow = flags_q.underflow;

endmodule

// File: tb/tb_fpu_div_seq.sv
// Bench for fpu_div_seq: directed corner cases plus random operands checked
// against a real-arithmetic reference with DAZ/FTZ and special-case rules.
module tb_fpu_div_seq;

    localparam logic [63:0] NAN_Q = 64'h7FF8000000000000;
    localparam logic [63:0] SIX   = 64'h4018000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;
    logic        flag_invalid;
    logic        flag_divzero;
    logic        flag_overflow;
    logic        flag_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fpu_div_seq dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_invalid   (flag_invalid),
        .flag_divzero   (flag_divzero),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Flags packed as {invalid, divzero, overflow, underflow}.
    function automatic void ref_div(input logic [63:0] x, input logic [63:0] y,
                                    output logic [63:0] q, output logic [3:0] f,
                                    output bit sp);
        bit xz, xi, xn, yz, yi, yn;
        logic s;
        logic [63:0] inf, zero, rb;
        real r;
        xz = (x[62:52] == 11'h000);
        xi = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
        xn = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
        yz = (y[62:52] == 11'h000);
        yi = (y[62:52] == 11'h7FF) && (y[51:0] == 52'd0);
        yn = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
        s    = x[63] ^ y[63];
        inf  = {s, 11'h7FF, 52'd0};
        zero = {s, 63'd0};
        f    = 4'b0000;
        sp   = 1'b1;
        q    = '0;
        if (xn || yn) q = NAN_Q;
        else if ((xz && yz) || (xi && yi)) begin q = NAN_Q; f = 4'b1000; end
        else if (yz) begin q = inf; f = xi ? 4'b0000 : 4'b0100; end
        else if (xz) q = zero;
        else if (xi) q = inf;
        else if (yi) q = zero;
        else begin
            sp = 1'b0;
            r  = $bitstoreal(x) / $bitstoreal(y);
            rb = $realtobits(r);
            if (rb[62:52] == 11'h7FF) begin q = inf; f = 4'b0010; end
            else if (rb[62:52] == 11'h000) begin q = zero; f = 4'b0001; end
            else q = rb;
        end
    endfunction

    // mode 0: mid-range normal, 1: may be zero/subnormal/Inf/NaN, 2: huge, 3: tiny
    function automatic logic [63:0] rnd_fp(input int mode);
        logic [10:0] e;
        logic [51:0] fr;
        int k;
        fr = 52'({$urandom(), $urandom()});
        k  = int'($urandom_range(0, 15));
        case (mode)
            2: e = 11'($urandom_range(1900, 2046));
            3: e = 11'($urandom_range(1, 100));
            default: begin
                e = 11'($urandom_range(700, 1300));
                if (mode == 1 && k < 2) begin
                    e = (k == 0) ? 11'h000 : 11'h7FF;
                    if ($urandom_range(0, 1) == 0) fr = '0;
                end
            end
        endcase
        return {1'($urandom()), e, fr};
    endfunction

    task automatic do_op(input logic [63:0] op_a, input logic [63:0] op_b,
                         input int hold, input string tag);
        logic [63:0] er;
        logic [3:0]  ef;
        bit          sp;
        int          lat;
        int          w;
        ref_div(op_a, op_b, er, ef, sp);
        w = 0;
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        chk({tag, "/ready"}, 64'(in_ready), 64'd1);
        if (!in_ready) return;
        in_valid = 1'b1;
        a = op_a;
        b = op_b;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
        end while (!out_valid && lat < 100);
        chk({tag, "/lat"}, 64'(lat), sp ? 64'd1 : 64'd57);
        chk({tag, "/res"}, result, er);
        chk({tag, "/flags"}, 64'({flag_invalid, flag_divzero, flag_overflow, flag_underflow}), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_res"}, result, er);
            chk({tag, "/hold_hs"}, 64'({out_valid, in_ready}), 64'b10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/back_idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hs", 64'({in_ready, out_valid}), 64'd0);
        chk("rst_res", result, 64'd0);
        chk("rst_flags", 64'({flag_invalid, flag_divzero, flag_overflow, flag_underflow}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 64'(in_ready), 64'd1);

        do_op(SIX, TWO, 0, "six_div_two");
        do_op(ONE, 64'h4008000000000000, 0, "one_div_three");
        do_op(ONE, 64'h0000000000000000, 0, "one_div_zero");
        do_op(64'h8000000000000000, 64'h0000000000000000, 0, "zero_div_zero");
        do_op(64'h7FF0000000000001, ONE, 0, "nan_div_one");
        do_op(64'hFFF0000000000000, 64'h7FF0000000000000, 0, "inf_div_inf");
        do_op(64'h0000000000000001, ONE, 0, "daz_dividend");
        do_op(ONE, 64'h800FFFFFFFFFFFFF, 0, "daz_divisor");
        do_op(64'hC000000000000000, 64'h7FF0000000000000, 0, "x_div_inf");
        do_op(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 0, "overflow");
        do_op(64'h0010000000000000, TWO, 0, "underflow");
        do_op(SIX, TWO, 10, "backpressure");

        // Abort mid-divide with reset, then confirm the unit recovers.
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        a = SIX;
        b = TWO;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_hs", 64'({out_valid, in_ready}), 64'd0);
        chk("midrst_flags", 64'({flag_invalid, flag_divzero, flag_overflow, flag_underflow}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release", 64'({out_valid, in_ready}), 64'b01);
        do_op(SIX, TWO, 0, "after_reset");

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1:    do_op(rnd_fp(1), rnd_fp(1), int'($urandom_range(0, 3)), "rand_special");
                2:       do_op(rnd_fp(2), rnd_fp(3), 0, "rand_ovf");
                3:       do_op(rnd_fp(3), rnd_fp(2), 0, "rand_unf");
                default: do_op(rnd_fp(0), rnd_fp(0), int'($urandom_range(0, 2)), "rand_normal");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_div_seq.md
# fpu_div_seq

Iterative, multi-cycle IEEE-754 double-precision divider with a valid/ready handshake on both sides. It is sequenced by an internal state machine that classifies operands, runs one radix-2 restoring quotient step per cycle, then rounds and packs the result. It is the FPU's shared divide resource: one operation in flight, producing one quotient bit per clock instead of a single wide combinational divide.

## Interface
Parameters:
- none (format fixed to binary64)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept operands
- a  in  64  dividend (binary64)
- b  in  64  divisor (binary64)
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  64  quotient (binary64)
- flag_invalid  out  1  0/0 or Inf/Inf
- flag_divzero  out  1  finite nonzero / zero
- flag_overflow  out  1  result rounded to Inf
- flag_underflow  out  1  nonzero result flushed to zero

## Operation
- States: IDLE, DIVIDE, ROUND, DONE.
- IDLE: in_ready=1. Accept on in_valid&in_ready; register sign=a[63]^b[63] and classify both operands.
- Subnormal inputs treated as zero, keeping their sign (DAZ). No subnormal outputs are produced (FTZ).
- Special cases (priority order) go IDLE->DONE directly:
  - any NaN -> 0x7FF8000000000000, no flag
  - 0/0 or Inf/Inf -> 0x7FF8000000000000, flag_invalid
  - x/0 -> signed Inf, flag_divzero
  - 0/x -> signed zero
  - Inf/x -> signed Inf
  - x/Inf -> signed zero
- Normal: go to DIVIDE with R=1.frac_a (53b), D=1.frac_b, and a 6-bit counter=0.
- DIVIDE, per cycle: if R>=D then q bit=1 and R=R-D, else q bit=0; then R=R<<1. This is 55 iterations, filling q[54:0] MSB first. Exit after count 54.
- ROUND (1 cycle):
  - Exponent is a 13-bit signed value: e = ea - eb + 1023 - (q[54]?0:1).
  - q[54]=1: frac=q[53:2], guard=q[1], sticky=q[0]|(R!=0).
  - q[54]=0: frac=q[52:1], guard=q[0], sticky=(R!=0).
  - Round to nearest even: increment when guard&(sticky|frac[0]). A fraction carry-out clears frac and adds 1 to e.
  - e>=2047 -> signed Inf, flag_overflow.
  - e<=0 -> signed zero, flag_underflow.
- DONE: out_valid=1. Result and flags are held stable until out_ready; then return to IDLE.
- in_ready=0 outside IDLE. There is no same-cycle accept on the return to IDLE.

## Timing
- Reset: state=IDLE, and every output is 0 while rst is high. This includes in_ready=0 during reset. in_ready=1 on the first cycle after rst deasserts.
- Special-case latency: out_valid is asserted the cycle after the accept edge.
- Normal latency: DIVIDE takes 55 cycles and ROUND 1. out_valid is asserted 57 cycles after the accept edge.
- Throughput: one op per (latency + handshake + 1 IDLE cycle) at best.
- Backpressure: out_valid, result and flags stay constant while out_ready=0.
- Reset mid-operation aborts the op immediately. No output is produced for it, and flags clear.
- in_valid during non-IDLE states is ignored. Operands are captured only at accept.

## Structure
- Shared package fpu_pkg:
  - EXP_BIAS=1023, EXP_MAX=11'h7FF
  - QNAN=64'h7FF8000000000000
  - field widths (sign/exp/frac)
  - div_state_t enum
- Sub-module fpu_div_classify (combinational):
  - per-operand zero/inf/nan flags, with DAZ
  - special-case result and flag selection
- Remainder/quotient registers, counter and rounding live in fpu_div_seq.

## Test plan
- 6.0/2.0: a=0x4018000000000000, b=0x4000000000000000 -> result 0x4008000000000000, no flags, out_valid exactly 57 cycles after accept.
- 1.0/3.0: a=0x3FF0000000000000, b=0x4008000000000000 -> result 0x3FD5555555555555 (RNE check).
- 1.0/+0 -> 0x7FF0000000000000 with flag_divzero, 1-cycle latency. -0/+0 -> 0x7FF8000000000000 with flag_invalid. NaN/1.0 -> 0x7FF8000000000000, no flag.
- Range limits:
  - 0x7FEFFFFFFFFFFFFF/0x3FE0000000000000 -> 0x7FF0000000000000 with flag_overflow.
  - 0x0010000000000000/0x4000000000000000 -> 0x0000000000000000 with flag_underflow.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0; accept completes on out_ready.
- Reset mid-op: assert rst at DIVIDE cycle 20 -> out_valid=0 immediately, in_ready=1 the cycle after release. The next op, 6.0/2.0, must still return 0x4008000000000000.
